// File: rtl/accumulator.sv
// accumulator: program-counter / fetch-offset register for the UM control unit.
//
// Holds the current instruction offset driven onto mem_ctrl.offset. It is cleared
// on init, advanced once per FETCH, held during EXECUTE/CONTINUE, and loaded with
// a new offset on program load.
//
// Build option:
//   ACC_REL_JUMP_EN  when defined, command 10 adds in_val to the current value
//                    (relative jump) and wrap reports that add's carry-out.
//                    When undefined (default), command 10 is an absolute load.
//
// Parameters:
//   WIDTH  accumulator/data width in bits
//   STEP   increment applied on an advance command
//
// Ports:
//   in_val  in   WIDTH  load operand (new offset)
//   ctrl    in   2      00 hold, 01 advance, 10 load, 11 clear
//   clk     in   1      rising-edge clock
//   out     out  WIDTH  current accumulator value (registered)
//   wrap    out  1      one-cycle pulse: previous add carried out of the MSB
//   rst_n   in   1      asynchronous reset, active low
module accumulator #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic [WIDTH-1:0] in_val,
  input  logic [1:0]       ctrl,
  input  logic             clk,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  input  logic             rst_n
);

  typedef enum logic [1:0] {
    CmdHold    = 2'b00,
    CmdAdvance = 2'b01,
    CmdLoad    = 2'b10,
    CmdClear   = 2'b11
  } cmd_e;

  // STEP truncated to the datapath width; the add is modulo 2^WIDTH anyway.
  localparam logic [WIDTH-1:0] StepVal = WIDTH'(STEP);

  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  // One shared adder: advance always adds STEP; in the relative-jump build a
  // load adds in_val through the same adder so both report carry identically.
  always_comb begin
    addend = StepVal;
`ifdef ACC_REL_JUMP_EN
    if (ctrl == CmdLoad) begin
      addend = in_val;
    end
`endif
  end

  assign sum = {1'b0, out_q} + {1'b0, addend};

  // Unknown ctrl values fall into the default branch, so out holds rather
  // than absorbing X.
  always_comb begin
    out_d  = out_q;
    wrap_d = 1'b0;
    case (ctrl)
      CmdHold: begin
        out_d  = out_q;
        wrap_d = 1'b0;
      end
      CmdAdvance: begin
        out_d  = sum[WIDTH-1:0];
        wrap_d = sum[WIDTH];
      end
      CmdLoad: begin
`ifdef ACC_REL_JUMP_EN
        out_d  = sum[WIDTH-1:0];
        wrap_d = sum[WIDTH];
`else
        out_d  = in_val;
        wrap_d = 1'b0;
`endif
      end
      CmdClear: begin
        out_d  = '0;
        wrap_d = 1'b0;
      end
      default: begin
        out_d  = out_q;
        wrap_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign out  = out_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_accumulator.sv
// tb_accumulator: scoreboard bench for accumulator (WIDTH=32, STEP=1).
// The driver pushes the expected post-edge value for every command it issues;
// an independent monitor pops and compares one entry after each rising edge.
// Expectations for command 10 follow ACC_REL_JUMP_EN when it is defined.
module tb_accumulator;

  localparam int unsigned WIDTH = 32;

  logic [WIDTH-1:0] in_val;
  logic [1:0]       ctrl;
  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] out;
  logic             wrap;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] out;
    logic             wrap;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  accumulator #(
    .WIDTH (WIDTH),
    .STEP  (1)
  ) dut (
    .in_val (in_val),
    .ctrl   (ctrl),
    .clk    (clk),
    .out    (out),
    .wrap   (wrap),
    .rst_n  (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act_out, input logic act_wrap,
                       input logic [WIDTH-1:0] exp_out, input logic exp_wrap);
    n_tests++;
    if (act_out !== exp_out || act_wrap !== exp_wrap) begin
      n_fail++;
      $display("FAIL %s: got out=%h wrap=%b, expected out=%h wrap=%b",
               name, act_out, act_wrap, exp_out, exp_wrap);
    end
  endtask

  // Drive a command at the falling edge; it takes effect at the next rising edge.
  task automatic issue(input string name, input logic [1:0] c, input logic [WIDTH-1:0] v,
                       input logic [WIDTH-1:0] exp_out, input logic exp_wrap);
    exp_t e;
    @(negedge clk);
    ctrl   = c;
    in_val = v;
    e.name = name;
    e.out  = exp_out;
    e.wrap = exp_wrap;
    sb_q.push_back(e);
  endtask

  // Monitor: one expected entry per rising edge, sampled just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.name, out, wrap, e.out, e.wrap);
    end
  end

  initial begin
    rst_n  = 1'b0;
    ctrl   = 2'b00;
    in_val = '0;
    #1;
    check("reset_init", out, wrap, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    issue("clear0",    2'b11, 32'h0, 32'h0, 1'b0);
    issue("adv1",      2'b01, 32'h0, 32'h1, 1'b0);
    issue("adv2",      2'b01, 32'h0, 32'h2, 1'b0);
    issue("adv3",      2'b01, 32'h0, 32'h3, 1'b0);
    issue("hold3",     2'b00, 32'hDEAD_BEEF, 32'h3, 1'b0);
    issue("xctrl",     2'bxx, 32'hDEAD_BEEF, 32'h3, 1'b0);
    issue("adv4",      2'b01, 32'h0, 32'h4, 1'b0);
    issue("adv5",      2'b01, 32'h0, 32'h5, 1'b0);

    // Asynchronous reset mid-count, away from any clock edge.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    ctrl  = 2'b00;
    #1;
    check("reset_async", out, wrap, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", out, wrap, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    issue("load7",     2'b10, 32'h7, 32'h7, 1'b0);
`ifdef ACC_REL_JUMP_EN
    issue("load100",   2'b10, 32'h100, 32'h107, 1'b0);
`else
    issue("load100",   2'b10, 32'h100, 32'h100, 1'b0);
`endif
    issue("clr_a",     2'b11, 32'h0, 32'h0, 1'b0);
    issue("load1234",  2'b10, 32'h1234, 32'h1234, 1'b0);
    issue("clr_1234",  2'b11, 32'h0, 32'h0, 1'b0);
    issue("adv_after", 2'b01, 32'h0, 32'h1, 1'b0);

    issue("clr_b",     2'b11, 32'h0, 32'h0, 1'b0);
    issue("load_max",  2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue("adv_wrap",  2'b01, 32'h0, 32'h0, 1'b1);
    issue("wrap_drop", 2'b00, 32'h0, 32'h0, 1'b0);
    issue("adv_nowrap", 2'b01, 32'h0, 32'h1, 1'b0);

    issue("clr_c",     2'b11, 32'h0, 32'h0, 1'b0);
    issue("load_fff0", 2'b10, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 1'b0);
`ifdef ACC_REL_JUMP_EN
    issue("rel_wrap",  2'b10, 32'h20, 32'h10, 1'b1);
    issue("rel_hold",  2'b00, 32'h0, 32'h10, 1'b0);
`else
    issue("abs_load",  2'b10, 32'h20, 32'h20, 1'b0);
    issue("abs_hold",  2'b00, 32'h0, 32'h20, 1'b0);
`endif

    // Let the monitor drain; a leftover entry means an output was never seen.
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
